// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/busy/done handshake and result bundle between sequencer and alu_seq
interface alu_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   res;
  logic               cout;
  logic               ovf;
  logic               zero;
  logic               neg;

  modport master (
    output start, op, a, b, cin, shamt,
    input  busy, done, res, cout, ovf, zero, neg
  );

  modport slave (
    input  start, op, a, b, cin, shamt,
    output busy, done, res, cout, ovf, zero, neg
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with N/Z/C/V flags and one-bit-per-clock shifts/rotates
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ASL = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   b_int;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   step_acc;
  logic               step_carry;
  logic               is_shift;

  always_comb begin
    b_int    = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum      = {1'b0, bus.a} + {1'b0, b_int} + {{WIDTH{1'b0}}, bus.cin};
    is_shift = (bus.op >= OP_LSR) && (bus.op <= OP_ROL);

    // One step on the {carry, acc} pair for the captured shift kind.
    step_acc   = acc_q;
    step_carry = carry_q;
    case (op_q)
      OP_LSR: begin
        step_carry = acc_q[0];
        step_acc   = {1'b0, acc_q[WIDTH-1:1]};
      end
      OP_ASL: begin
        step_carry = acc_q[WIDTH-1];
        step_acc   = {acc_q[WIDTH-2:0], 1'b0};
      end
      OP_ROR: begin
        step_carry = acc_q[0];
        step_acc   = {carry_q, acc_q[WIDTH-1:1]};
      end
      OP_ROL: begin
        step_carry = acc_q[WIDTH-1];
        step_acc   = {acc_q[WIDTH-2:0], carry_q};
      end
      default: ;
    endcase

    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (bus.shamt != '0)) begin
            acc_d   = bus.a;
            carry_d = bus.cin;
            cnt_d   = bus.shamt;
            op_d    = bus.op;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
            case (bus.op)
              OP_ADD, OP_SUB: begin
                res_d  = sum[WIDTH-1:0];
                cout_d = sum[WIDTH];
                ovf_d  = (bus.a[WIDTH-1] == b_int[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
              end
              OP_AND: res_d = bus.a & bus.b;
              OP_EOR: res_d = bus.a ^ bus.b;
              OP_OR:  res_d = bus.a | bus.b;
              OP_LSR, OP_ASL, OP_ROR, OP_ROL: begin
                res_d  = bus.a;
                cout_d = bus.cin;
              end
              default: res_d = '0;
            endcase
            zero_d = (res_d == '0);
            neg_d  = res_d[WIDTH-1];
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d   = step_acc;
        carry_d = step_carry;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = step_acc;
          cout_d  = step_carry;
          ovf_d   = 1'b0;
          zero_d  = (step_acc == '0);
          neg_d   = step_acc[WIDTH-1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alu_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, res}; shifts/rotates are evaluated as whole n-bit moves.
  function automatic logic [9:0] model(input logic [3:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic c, input logic [2:0] s);
    int v, r, si;
    logic [7:0] res, bi;
    logic cy, ov;
    si = int'(s);
    cy = 1'b0;
    ov = 1'b0;
    v  = {23'd0, c, a};
    case (o)
      4'd0, 4'd1: begin
        bi  = (o == 4'd1) ? ~b : b;
        r   = int'(a) + int'(bi) + int'(c);
        res = r[7:0];
        cy  = r[8];
        ov  = (a[7] == bi[7]) && (res[7] != a[7]);
      end
      4'd2: res = a & b;
      4'd3: res = a ^ b;
      4'd4: res = a | b;
      4'd5: begin
        res = a >> si;
        cy  = (si == 0) ? c : a[si-1];
      end
      4'd6: begin
        res = a << si;
        cy  = (si == 0) ? c : a[8-si];
      end
      4'd7: begin
        r   = ((v >> si) | (v << (9 - si))) & 'h1FF;
        res = r[7:0];
        cy  = r[8];
      end
      4'd8: begin
        r   = ((v << si) | (v >> (9 - si))) & 'h1FF;
        res = r[7:0];
        cy  = r[8];
      end
      default: res = 8'h00;
    endcase
    return {ov, cy, res};
  endfunction

  task automatic check_outs(input string tag, input logic [9:0] m);
    chk({tag, ".res"},  bus.res,  m[7:0]);
    chk({tag, ".cout"}, bus.cout, m[8]);
    chk({tag, ".ovf"},  bus.ovf,  m[9]);
    chk({tag, ".zero"}, bus.zero, m[7:0] == 8'h00);
    chk({tag, ".neg"},  bus.neg,  m[7]);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [2:0] s,
                        input bit stall_start);
    logic [9:0] m;
    int lat;
    m   = model(o, a, b, c, s);
    lat = (o >= 4'd5 && o <= 4'd8) ? int'(s) : 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = a; bus.b = b; bus.cin = c; bus.shamt = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
    bus.op = 4'($urandom); bus.shamt = 3'($urandom);
    if (lat == 0) begin
      chk({tag, ".done0"}, bus.done, 1'b1);
      chk({tag, ".busy0"}, bus.busy, 1'b0);
      check_outs(tag, m);
    end else begin
      chk({tag, ".busy0"}, bus.busy, 1'b1);
      chk({tag, ".done0"}, bus.done, 1'b0);
      for (int k = 1; k <= lat; k++) begin
        if (stall_start && k == 2) begin
          bus.start = 1'b1; bus.op = 4'd0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (k < lat) begin
          chk({tag, ".busy_mid"}, bus.busy, 1'b1);
          chk({tag, ".done_mid"}, bus.done, 1'b0);
        end else begin
          chk({tag, ".done_end"}, bus.done, 1'b1);
          chk({tag, ".busy_end"}, bus.busy, 1'b0);
          check_outs(tag, m);
        end
      end
    end
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, bus.done, 1'b0);
    chk({tag, ".busy_idle"}, bus.busy, 1'b0);
    chk({tag, ".res_hold"},  bus.res,  m[7:0]);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 4'd0; bus.a = 8'd0; bus.b = 8'd0; bus.cin = 1'b0; bus.shamt = 3'd0;
    #1;
    chk("rst.res",  bus.res,  8'h00);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op("add_ovf",  4'd0, 8'h7F, 8'h01, 1'b0, 3'd0, 1'b0);
    run_op("sub_zero", 4'd1, 8'h50, 8'h50, 1'b1, 3'd0, 1'b0);
    run_op("sub_brw",  4'd1, 8'h00, 8'h01, 1'b1, 3'd0, 1'b0);
    run_op("ror3",     4'd7, 8'h01, 8'h00, 1'b1, 3'd3, 1'b0);
    run_op("asl0",     4'd6, 8'h81, 8'h00, 1'b1, 3'd0, 1'b0);
    run_op("rol1",     4'd8, 8'h80, 8'h00, 1'b0, 3'd1, 1'b0);
    run_op("lsr7_stall", 4'd5, 8'hFF, 8'h00, 1'b0, 3'd7, 1'b1);
    run_op("rsvd",     4'd12, 8'hAA, 8'h55, 1'b1, 3'd2, 1'b0);

    // Abort a long shift mid-way with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd5; bus.a = 8'hFF; bus.cin = 1'b0; bus.shamt = 3'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort.res",  bus.res,  8'h00);
    chk("abort.busy", bus.busy, 1'b0);
    chk("abort.done", bus.done, 1'b0);
    chk("abort.flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort.no_done", {bus.done, bus.busy}, 2'b00);
    end
    run_op("add_after_rst", 4'd0, 8'h01, 8'h01, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
